dmem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port data memory between the processor load/store path (port 0) and a secondary master such as a loader or DMA engine (port 1). It sits directly in front of the data memory, drives its write enable, address and write data, and returns read data and a per-beat acknowledge to the granted requester. Grants are registered, bursts are bounded so neither port can starve the other, and all memory control outputs are forced inactive when no grant is held.

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port data
// memory. Port 0 is the processor load/store path, port 1 a secondary master.
// Grants are registered; a burst is capped at MAX_BURST beats when the other
// port is waiting. Memory controls are forced to 0 outside an active beat.
// Optional feature: define DMEM_ARB_STALL_CNT_EN to build the 16-bit
// saturating contention counter on stall_cnt_o (tied to 0 otherwise).
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          ack0_o,
    output logic          ack1_o,
    output logic [DW-1:0] rdata_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [15:0]   stall_cnt_o
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          last, last_nxt;
    logic [BW-1:0] beat_cnt, beat_cnt_nxt;
    logic [1:0]    arb_pick;
    logic          beat0, beat1, other_req;

    // A beat happens only when the granted port is still requesting.
    assign beat0     = (state == GNT0) && req0_i;
    assign beat1     = (state == GNT1) && req1_i;
    assign other_req = beat0 ? req1_i : req0_i;

    // Fresh arbitration used from IDLE or from a grant whose owner went quiet.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        arb_pick = IDLE;
        if (req0_i && req1_i) begin
            arb_pick = last ? GNT0 : GNT1;
        end else if (req0_i) begin
            arb_pick = GNT0;
        end else if (req1_i) begin
            arb_pick = GNT1;
        end
    end

    // Next grant, burst counter and round-robin pointer.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        beat_cnt_nxt = beat_cnt;
        if (beat0 || beat1) begin
            if (beat_cnt != LAST_BEAT) begin
                beat_cnt_nxt = beat_cnt + BW'(1);
            end else begin
                beat_cnt_nxt = '0;
                if (other_req) begin
                    state_nxt = beat0 ? GNT1 : GNT0;
                    last_nxt  = beat0;
                end
            end
        end else begin
            state_nxt    = arb_pick;
            beat_cnt_nxt = '0;
            if (arb_pick == GNT0) begin
                last_nxt = 1'b0;
            end else if (arb_pick == GNT1) begin
                last_nxt = 1'b1;
            end
        end
    end

    // Grant state registers; last resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            beat_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state    <= state_nxt;
            last     <= last_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Memory and requester outputs, driven only during an active beat.
    always_comb begin
        ack0_o      = beat0;
        ack1_o      = beat1;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rdata_o     = '0;
        if (beat0) begin
            mem_we_o    = we0_i;
            mem_addr_o  = addr0_i;
            mem_wdata_o = wdata0_i;
            rdata_o     = mem_rdata_i;
        end else if (beat1) begin
            mem_we_o    = we1_i;
            mem_addr_o  = addr1_i;
            mem_wdata_o = wdata1_i;
            rdata_o     = mem_rdata_i;
        end
    end

`ifdef DMEM_ARB_STALL_CNT_EN
    logic        wait0, wait1;
    logic [16:0] stall_sum;

    assign wait0     = req0_i && !beat0;
    assign wait1     = req1_i && !beat1;
    assign stall_sum = {1'b0, stall_cnt_o} + {16'd0, wait0} + {16'd0, wait1};

    // Adds the number of waiting ports each cycle, saturating at 0xFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (stall_sum[16]) begin
            stall_cnt_o <= 16'hFFFF;
        end else begin
            stall_cnt_o <= stall_sum[15:0];
        end
    end
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven directed vectors, hand-written multi-cycle
// sequences (contention, reset mid-burst, long single-port run) and a random
// phase compared against a cycle-level behavioural model of the arbiter.
module tb_dmem_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack0, ack1, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] stall_cnt;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[3:0]];

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_i     (req[0]),
        .req1_i     (req[1]),
        .we0_i      (we[0]),
        .we1_i      (we[1]),
        .addr0_i    (addr[0]),
        .addr1_i    (addr[1]),
        .wdata0_i   (wdata[0]),
        .wdata1_i   (wdata[1]),
        .ack0_o     (ack0),
        .ack1_o     (ack1),
        .rdata_o    (rdata),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .stall_cnt_o(stall_cnt)
    );

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        k0, k1, mwe;
        logic [31:0] ma, md, rd;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mkv(input logic r0, w0, input logic [31:0] a0, d0,
                                 input logic r1, w1, input logic [31:0] a1, d1,
                                 input logic k0, k1, mwe,
                                 input logic [31:0] ma, md, rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.k0 = k0; v.k1 = k1; v.mwe = mwe; v.ma = ma; v.md = md; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: commit the memory write seen this cycle at the
    // coming rising edge, then return 1 time unit after that edge.
    task automatic tick();
        logic        w;
        logic [31:0] a, d;
        w = mem_we; a = mem_addr; d = mem_wdata;
        @(posedge clk);
        if (w) mem[a[3:0]] = d;
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
        req[p] = r; we[p] = w; addr[p] = a; wdata[p] = d;
    endtask

    // Called 1 unit after a rising edge; returns 1 unit after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] stall_exp(input int n);
`ifdef DMEM_ARB_STALL_CNT_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    initial begin
        int          owner, beats, last_m, stall_m;
        logic        e_ack [2];
        logic        active, a_seen [2];
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic        e_we;

        // Directed vectors: port 0 read of a preloaded word, port 1 write,
        // then port 0 reads the written word back.
        vecs[0] = mkv(1, 0, 5, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0);
        vecs[1] = mkv(1, 0, 5, 0, 0, 0, 0, 0,         1, 0, 0, 5, 0, 32'hA5);
        vecs[2] = mkv(0, 0, 5, 0, 1, 1, 0, 32'h1234,  0, 0, 0, 0, 0, 0);
        vecs[3] = mkv(0, 0, 5, 0, 1, 1, 0, 32'h1234,  0, 1, 1, 0, 32'h1234, 0);
        vecs[4] = mkv(1, 0, 0, 0, 0, 1, 0, 32'h1234,  0, 0, 0, 0, 0, 0);
        vecs[5] = mkv(1, 0, 0, 0, 0, 1, 0, 32'h1234,  1, 0, 0, 0, 0, 32'h1234);
        vecs[6] = mkv(0, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0);
        vecs[7] = mkv(0, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[5] = 32'hA5;

        // Reset state: a request during reset must not be acknowledged.
        rst_n = 1'b0;
        set_port(0, 1, 0, 5, 0);
        set_port(1, 1, 1, 7, 32'h55);
        @(negedge clk);
        check("rst_ack0", {31'd0, ack0}, 0);
        check("rst_ack1", {31'd0, ack1}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_stall", {16'd0, stall_cnt}, 0);
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            set_port(0, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0);
            set_port(1, vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            check($sformatf("vec%0d_ack0", i), {31'd0, ack0}, {31'd0, vecs[i].k0});
            check($sformatf("vec%0d_ack1", i), {31'd0, ack1}, {31'd0, vecs[i].k1});
            check($sformatf("vec%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].mwe});
            check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].ma);
            check($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].md);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rd);
            tick();
        end

        // Contention: both ports hold reads; bursts of MAX_BURST alternate
        // with no bubble, port 0 first. Cycle 0 is IDLE with both waiting.
        do_reset();
        set_port(0, 1, 0, 1, 0);
        set_port(1, 1, 0, 2, 0);
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            check($sformatf("cont%0d_ack0", k), {31'd0, ack0},
                  {31'd0, (k >= 1) && (((k - 1) / MAX_BURST) % 2 == 0)});
            check($sformatf("cont%0d_ack1", k), {31'd0, ack1},
                  {31'd0, (k >= 1) && (((k - 1) / MAX_BURST) % 2 == 1)});
            check($sformatf("cont%0d_stall", k), {16'd0, stall_cnt},
                  {16'd0, stall_exp((k == 0) ? 0 : k + 1)});
            if (k < 21) tick();
        end

        // Reset during a port-1 beat: outputs drop at once; afterwards the
        // still-pending tie goes to port 0.
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_ack1", {31'd0, ack1}, 0);
        check("rstmid_ack0", {31'd0, ack0}, 0);
        check("rstmid_mem_addr", mem_addr, 0);
        check("rstmid_rdata", rdata, 0);
        check("rstmid_stall", {16'd0, stall_cnt}, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_ack0", {31'd0, ack0}, 1);
        check("post_rst_ack1", {31'd0, ack1}, 0);
        tick();

        // Port 0 alone: ten back-to-back beats across beat counter wraps.
        do_reset();
        set_port(0, 1, 0, 0, 0);
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            check($sformatf("run%0d_ack0", k), {31'd0, ack0},
                  {31'd0, (k >= 1) && (k <= 10)});
            check($sformatf("run%0d_mem_addr", k), mem_addr,
                  ((k >= 1) && (k <= 10)) ? 32'(k - 1) : 32'd0);
            tick();
            if (k >= 1 && k < 10) addr[0] = addr[0] + 1;
            if (k == 10) req[0] = 1'b0;
        end

        // Random traffic against the behavioural model.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'hC0DE_0000 + 32'(i);
            ref_mem[i] = 32'hC0DE_0000 + 32'(i);
        end
        owner = -1; beats = 0; last_m = 1; stall_m = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            active   = (owner >= 0) && req[owner];
            e_ack[0] = active && (owner == 0);
            e_ack[1] = active && (owner == 1);
            e_we     = active ? we[owner]    : 1'b0;
            e_addr   = active ? addr[owner]  : 32'd0;
            e_wdata  = active ? wdata[owner] : 32'd0;
            e_rdata  = active ? ref_mem[addr[owner][3:0]] : 32'd0;
            check("rnd_ack0", {31'd0, ack0}, {31'd0, e_ack[0]});
            check("rnd_ack1", {31'd0, ack1}, {31'd0, e_ack[1]});
            check("rnd_mem_we", {31'd0, mem_we}, {31'd0, e_we});
            check("rnd_mem_addr", mem_addr, e_addr);
            check("rnd_mem_wdata", mem_wdata, e_wdata);
            check("rnd_rdata", rdata, e_rdata);
            check("rnd_stall", {16'd0, stall_cnt}, {16'd0, stall_exp(stall_m)});

            for (int p = 0; p < 2; p++)
                if (req[p] && !e_ack[p]) stall_m++;
            if (active) begin
                if (we[owner]) ref_mem[addr[owner][3:0]] = wdata[owner];
                beats++;
                if (beats == MAX_BURST) begin
                    beats = 0;
                    if (req[1 - owner]) begin
                        owner  = 1 - owner;
                        last_m = owner;
                    end
                end
            end else begin
                if (req[0] && req[1]) owner = 1 - last_m;
                else if (req[0])      owner = 0;
                else if (req[1])      owner = 1;
                else                  owner = -1;
                if (owner >= 0) last_m = owner;
                beats = 0;
            end

            a_seen[0] = ack0;
            a_seen[1] = ack1;
            tick();
            for (int p = 0; p < 2; p++) begin
                if (!req[p]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_port(p, 1, 1'($urandom_range(1, 0)), 32'($urandom_range(15, 0)), $urandom);
                end else if (a_seen[p]) begin
                    if ($urandom_range(3, 0) != 0)
                        set_port(p, 1, 1'($urandom_range(1, 0)), 32'($urandom_range(15, 0)), $urandom);
                    else
                        req[p] = 1'b0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
